// File: rtl/bridge_fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_fc_pkg
//  Description : Shared types and constants for the transmit flow-control
//                credit gate (credit-type encodings, fc_sel code, widths,
//                FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package bridge_fc_pkg;

    // Credit counter widths as presented by the core
    localparam int HDR_W      = 8;
    localparam int DATA_W     = 12;
    localparam int REQ_DATA_W = 10;

    // Request type encodings from the TLP builder
    localparam logic [1:0] FC_POSTED    = 2'd0;
    localparam logic [1:0] FC_NONPOSTED = 2'd1;
    localparam logic [1:0] FC_CPL       = 2'd2;
    localparam logic [1:0] FC_ILLEGAL   = 2'd3;

    // fc_sel code asking the core for transmit-available credits
    localparam logic [2:0] FC_SEL_TX_AVAIL = 3'b100;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SEL = 3'd1,
        SNAP     = 3'd2,
        SERVE    = 3'd3,
        GRANT    = 3'd4
    } fc_state_t;

    // Widen a request data-credit amount to the data counter width
    function automatic logic [DATA_W-1:0] req_to_data(input logic [REQ_DATA_W-1:0] amt);
        return {{(DATA_W-REQ_DATA_W){1'b0}}, amt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_fc_credit.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_fc_credit
//  Description : One local credit counter: snapshot load, decrement by an
//                amount, sufficiency compare and registered watermark flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bridge_fc_credit #(
    parameter int W  = 8,
    parameter int WM = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    input  logic [W-1:0] i_dec_amt,
    input  logic [W-1:0] i_need,
    output logic         o_suff,
    output logic         o_flag
);

    localparam logic [W-1:0] c_WM = W'(WM);

    logic [W-1:0] r_count;
    logic         r_flag;

    // Credit count: clear wins, then snapshot load, then consumption
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - i_dec_amt;
        end
    end

    // Watermark flag follows the count one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
        end else if (i_clr) begin
            r_flag <= 1'b0;
        end else begin
            r_flag <= (r_count >= c_WM);
        end
    end

    assign o_suff = (r_count >= i_need);
    assign o_flag = r_flag;

endmodule
`default_nettype wire

// File: rtl/bridge_tx_fc_gate.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_tx_fc_gate
//  Description : Transmit-side flow-control gate. Snapshots the core's Tx
//                available credits, tracks them locally and grants or
//                withholds TLP requests from the transmit bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module bridge_tx_fc_gate
    import bridge_fc_pkg::*;
#(
    parameter int FC_SEL_LAT     = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int REFRESH_CYCLES = 64,
    parameter int HDR_WM         = 8,
    parameter int DATA_WM        = 32
) (
    input  logic                  Fc_CLK,
    input  logic                  Fc_RST,
    input  logic                  Fc_Bridge_Ready,
    input  logic [HDR_W-1:0]      Fc_fc_ph,
    input  logic [HDR_W-1:0]      Fc_fc_nph,
    input  logic [HDR_W-1:0]      Fc_fc_cplh,
    input  logic [DATA_W-1:0]     Fc_fc_pd,
    input  logic [DATA_W-1:0]     Fc_fc_npd,
    input  logic [DATA_W-1:0]     Fc_fc_cpld,
    output logic [2:0]            Fc_fc_sel,
    input  logic                  Fc_Req,
    input  logic [1:0]            Fc_Req_Type,
    input  logic [REQ_DATA_W-1:0] Fc_Req_Data,
    output logic                  Fc_Grant,
    output logic                  Fc_Req_Err,
    output logic [5:0]            Fc_Tx_FC
);

    localparam int c_WAIT_W   = (FC_SEL_LAT > 1) ? $clog2(FC_SEL_LAT) : 1;
    localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int c_IDLE_W   = $clog2(REFRESH_CYCLES + 1);

    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST   = c_WAIT_W'(FC_SEL_LAT - 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_ONE    = c_WAIT_W'(1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_ONE  = c_SETTLE_W'(1);
    localparam logic [c_IDLE_W-1:0]   c_REFRESH     = c_IDLE_W'(REFRESH_CYCLES);
    localparam logic [c_IDLE_W-1:0]   c_IDLE_ONE    = c_IDLE_W'(1);
    localparam logic [HDR_W-1:0]      c_HDR_ONE     = HDR_W'(1);

    fc_state_t r_state;
    fc_state_t w_next;

    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [c_SETTLE_W-1:0] r_settle;
    logic [c_IDLE_W-1:0]   r_idle;
    logic [1:0]            r_req_type;
    logic [DATA_W-1:0]     r_req_data;
    logic                  r_req_err;

    logic [HDR_W-1:0]  w_fc_hdr  [3];
    logic [DATA_W-1:0] w_fc_data [3];
    logic [2:0]        w_hdr_ok;
    logic [2:0]        w_data_ok;
    logic [2:0]        w_hdr_flag;
    logic [2:0]        w_data_flag;
    logic [DATA_W-1:0] w_req_data;
    logic              w_clr;
    logic              w_pass;
    logic              w_req_legal;
    logic              w_settled;
    logic              w_idle_expired;
    logic              w_grant;
    logic              w_err_set;

    assign w_fc_hdr[0]  = Fc_fc_ph;
    assign w_fc_hdr[1]  = Fc_fc_nph;
    assign w_fc_hdr[2]  = Fc_fc_cplh;
    assign w_fc_data[0] = Fc_fc_pd;
    assign w_fc_data[1] = Fc_fc_npd;
    assign w_fc_data[2] = Fc_fc_cpld;

    assign w_req_data     = req_to_data(Fc_Req_Data);
    assign w_clr          = ~Fc_Bridge_Ready;
    assign w_req_legal    = (Fc_Req_Type != FC_ILLEGAL);
    assign w_settled      = (r_settle == '0);
    assign w_idle_expired = (r_idle == c_REFRESH);

    // One header and one data counter per credit type; consumption uses the
    // type and amount latched while the request was evaluated in SERVE
    for (genvar gi = 0; gi < 3; gi++) begin : g_type
        logic w_dec;
        assign w_dec = w_grant && (r_req_type == 2'(gi));

        bridge_fc_credit #(.W(HDR_W), .WM(HDR_WM)) u_hdr (
            .clk        (Fc_CLK),
            .rst_n      (Fc_RST),
            .i_clr      (w_clr),
            .i_load     (r_state == SNAP),
            .i_load_val (w_fc_hdr[gi]),
            .i_dec      (w_dec),
            .i_dec_amt  (c_HDR_ONE),
            .i_need     (c_HDR_ONE),
            .o_suff     (w_hdr_ok[gi]),
            .o_flag     (w_hdr_flag[gi])
        );

        bridge_fc_credit #(.W(DATA_W), .WM(DATA_WM)) u_data (
            .clk        (Fc_CLK),
            .rst_n      (Fc_RST),
            .i_clr      (w_clr),
            .i_load     (r_state == SNAP),
            .i_load_val (w_fc_data[gi]),
            .i_dec      (w_dec),
            .i_dec_amt  (r_req_data),
            .i_need     (w_req_data),
            .o_suff     (w_data_ok[gi]),
            .o_flag     (w_data_flag[gi])
        );
    end

    // Sufficiency of the live request against the matching counter pair
    always_comb begin
        w_pass = 1'b0;
        case (Fc_Req_Type)
            FC_POSTED:    w_pass = w_hdr_ok[0] && w_data_ok[0];
            FC_NONPOSTED: w_pass = w_hdr_ok[1] && w_data_ok[1];
            FC_CPL:       w_pass = w_hdr_ok[2] && w_data_ok[2];
            default:      w_pass = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge Fc_CLK or negedge Fc_RST) begin
        if (!Fc_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and pulse decode; losing bridge-ready overrides everything
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_err_set = 1'b0;
        if (!Fc_Bridge_Ready) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: w_next = WAIT_SEL;
                WAIT_SEL: begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        w_next = SNAP;
                    end
                end
                SNAP: w_next = SERVE;
                SERVE: begin
                    if (Fc_Req) begin
                        if (!w_req_legal) begin
                            // Requester holds Req through the error pulse cycle
                            w_err_set = ~r_req_err;
                        end else if (w_pass) begin
                            w_next = GRANT;
                        end else if (w_settled) begin
                            w_next = WAIT_SEL;
                        end
                    end else if (w_idle_expired && w_settled) begin
                        w_next = WAIT_SEL;
                    end
                end
                GRANT: begin
                    w_grant = 1'b1;
                    w_next  = SERVE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // fc_sel latency counter, only runs while waiting in WAIT_SEL
    always_ff @(posedge Fc_CLK or negedge Fc_RST) begin
        if (!Fc_RST) begin
            r_wait_cnt <= '0;
        end else if ((r_state == WAIT_SEL) && (w_next == WAIT_SEL)) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Settle counter: armed by each grant, drains to zero in every state
    always_ff @(posedge Fc_CLK or negedge Fc_RST) begin
        if (!Fc_RST) begin
            r_settle <= '0;
        end else if (w_clr) begin
            r_settle <= '0;
        end else if (w_grant) begin
            r_settle <= c_SETTLE_LOAD;
        end else if (!w_settled) begin
            r_settle <= r_settle - c_SETTLE_ONE;
        end
    end

    // Idle timer: saturating count of request-free SERVE cycles
    always_ff @(posedge Fc_CLK or negedge Fc_RST) begin
        if (!Fc_RST) begin
            r_idle <= '0;
        end else if (w_clr || (r_state != SERVE)) begin
            r_idle <= '0;
        end else if (!Fc_Req && !w_idle_expired) begin
            r_idle <= r_idle + c_IDLE_ONE;
        end
    end

    // Latch the request while in SERVE so GRANT consumes what was checked
    always_ff @(posedge Fc_CLK or negedge Fc_RST) begin
        if (!Fc_RST) begin
            r_req_type <= FC_POSTED;
            r_req_data <= '0;
        end else if (r_state == SERVE) begin
            r_req_type <= Fc_Req_Type;
            r_req_data <= w_req_data;
        end
    end

    // Illegal-type error pulse, one cycle after the request is seen
    always_ff @(posedge Fc_CLK or negedge Fc_RST) begin
        if (!Fc_RST) begin
            r_req_err <= 1'b0;
        end else begin
            r_req_err <= w_err_set;
        end
    end

    assign Fc_fc_sel  = FC_SEL_TX_AVAIL;
    assign Fc_Grant   = w_grant;
    assign Fc_Req_Err = r_req_err;
    assign Fc_Tx_FC   = {w_data_flag[2], w_hdr_flag[2],
                         w_data_flag[1], w_hdr_flag[1],
                         w_data_flag[0], w_hdr_flag[0]};

endmodule
`default_nettype wire

// File: tb/tb_bridge_tx_fc_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bridge_tx_fc_gate
//  Description : Self-checking bench for bridge_tx_fc_gate. Expected request
//                outcomes are queued when a request is driven and compared
//                when the gate answers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bridge_tx_fc_gate;

    localparam int K_NONE  = 0;
    localparam int K_GRANT = 1;
    localparam int K_ERR   = 2;

    logic        Fc_CLK;
    logic        Fc_RST;
    logic        Fc_Bridge_Ready;
    logic [7:0]  Fc_fc_ph, Fc_fc_nph, Fc_fc_cplh;
    logic [11:0] Fc_fc_pd, Fc_fc_npd, Fc_fc_cpld;
    logic [2:0]  Fc_fc_sel;
    logic        Fc_Req;
    logic [1:0]  Fc_Req_Type;
    logic [9:0]  Fc_Req_Data;
    logic        Fc_Grant;
    logic        Fc_Req_Err;
    logic [5:0]  Fc_Tx_FC;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_q[$];

    bridge_tx_fc_gate dut (
        .Fc_CLK          (Fc_CLK),
        .Fc_RST          (Fc_RST),
        .Fc_Bridge_Ready (Fc_Bridge_Ready),
        .Fc_fc_ph        (Fc_fc_ph),
        .Fc_fc_nph       (Fc_fc_nph),
        .Fc_fc_cplh      (Fc_fc_cplh),
        .Fc_fc_pd        (Fc_fc_pd),
        .Fc_fc_npd       (Fc_fc_npd),
        .Fc_fc_cpld      (Fc_fc_cpld),
        .Fc_fc_sel       (Fc_fc_sel),
        .Fc_Req          (Fc_Req),
        .Fc_Req_Type     (Fc_Req_Type),
        .Fc_Req_Data     (Fc_Req_Data),
        .Fc_Grant        (Fc_Grant),
        .Fc_Req_Err      (Fc_Req_Err),
        .Fc_Tx_FC        (Fc_Tx_FC)
    );

    initial Fc_CLK = 1'b0;
    always #5 Fc_CLK = ~Fc_CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100us");
        $fatal(1);
    end

    // Advance n rising edges, leaving time at 1 unit after the edge
    task automatic step(input int n);
        repeat (n) @(posedge Fc_CLK);
        #1;
    endtask

    // Drive a request and queue its expected outcome
    task automatic send_req(input logic [1:0] t, input logic [9:0] d, input int exp_kind);
        Fc_Req_Type = t;
        Fc_Req_Data = d;
        Fc_Req      = 1'b1;
        exp_q.push_back(exp_kind);
    endtask

    // Watch falling edges for an answer, bounded by a cycle budget
    task automatic wait_resp(input int bound, output int kind, output int lat);
        kind = K_NONE;
        lat  = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge Fc_CLK);
            if (Fc_Grant === 1'b1) begin
                kind = K_GRANT;
                lat  = i;
                break;
            end
            if (Fc_Req_Err === 1'b1) begin
                kind = K_ERR;
                lat  = i;
                break;
            end
        end
    endtask

    // Requester drops Req in the cycle after the answer
    task automatic release_req();
        @(posedge Fc_CLK);
        #1;
        Fc_Req = 1'b0;
    endtask

    task automatic test_reset();
        step(3);
        total_cnt++;
        if (Fc_fc_sel !== 3'b100) $display("FAIL reset_fc_sel: got %b want 100", Fc_fc_sel); else pass_cnt++;
        total_cnt++;
        if (Fc_Grant !== 1'b0) $display("FAIL reset_grant: got %b want 0", Fc_Grant); else pass_cnt++;
        total_cnt++;
        if (Fc_Req_Err !== 1'b0) $display("FAIL reset_err: got %b want 0", Fc_Req_Err); else pass_cnt++;
        total_cnt++;
        if (Fc_Tx_FC !== 6'b0) $display("FAIL reset_tx_fc: got %b want 000000", Fc_Tx_FC); else pass_cnt++;
        Fc_RST = 1'b1;
        step(2);
        total_cnt++;
        if (Fc_fc_sel !== 3'b100) $display("FAIL run_fc_sel: got %b want 100", Fc_fc_sel); else pass_cnt++;
        total_cnt++;
        if (Fc_Tx_FC !== 6'b0) $display("FAIL idle_tx_fc: got %b want 000000", Fc_Tx_FC); else pass_cnt++;
    endtask

    task automatic test_snapshot();
        Fc_Bridge_Ready = 1'b1;
        step(2);
        total_cnt++;
        if (Fc_Tx_FC !== 6'b0) $display("FAIL pre_snap_tx_fc: got %b want 000000", Fc_Tx_FC); else pass_cnt++;
        step(6);
        total_cnt++;
        if (Fc_Tx_FC !== 6'b001011) $display("FAIL snap_tx_fc: got %b want 001011", Fc_Tx_FC); else pass_cnt++;
        total_cnt++;
        if (Fc_fc_sel !== 3'b100) $display("FAIL snap_fc_sel: got %b want 100", Fc_fc_sel); else pass_cnt++;
    endtask

    task automatic test_posted();
        int k, l, e;
        logic [9:0] amts [3];
        logic [5:0] want [3];
        amts[0] = 10'd40; want[0] = 6'b001011;  // ph 9,  pd 60
        amts[1] = 10'd40; want[1] = 6'b001001;  // ph 8,  pd 20
        amts[2] = 10'd20; want[2] = 6'b001000;  // ph 7,  pd 0
        for (int i = 0; i < 3; i++) begin
            send_req(2'd0, amts[i], K_GRANT);
            wait_resp(10, k, l);
            e = exp_q.pop_front();
            total_cnt++;
            if (k !== e) $display("FAIL posted_%0d_kind: got %0d want %0d", i, k, e); else pass_cnt++;
            total_cnt++;
            if (l !== 2) $display("FAIL posted_%0d_latency: got %0d want 2", i, l); else pass_cnt++;
            release_req();
            step(3);
            total_cnt++;
            if (Fc_Tx_FC !== want[i]) $display("FAIL posted_%0d_tx_fc: got %b want %b", i, Fc_Tx_FC, want[i]); else pass_cnt++;
        end
    endtask

    task automatic test_cpl_retry();
        int k, l, e;
        send_req(2'd2, 10'd50, K_GRANT);
        wait_resp(20, k, l);
        total_cnt++;
        if (k !== K_NONE) $display("FAIL cpl_short_withheld: got %0d want %0d", k, K_NONE); else pass_cnt++;
        @(posedge Fc_CLK);
        #1;
        Fc_fc_cpld = 12'd80;
        wait_resp(40, k, l);
        e = exp_q.pop_front();
        total_cnt++;
        if (k !== e) $display("FAIL cpl_retry_kind: got %0d want %0d", k, e); else pass_cnt++;
        release_req();
        step(3);
        total_cnt++;
        if (Fc_Tx_FC !== 6'b001011) $display("FAIL cpl_retry_tx_fc: got %b want 001011", Fc_Tx_FC); else pass_cnt++;
    endtask

    task automatic test_illegal();
        int k, l, e;
        send_req(2'd3, 10'd5, K_ERR);
        wait_resp(10, k, l);
        e = exp_q.pop_front();
        total_cnt++;
        if (k !== e) $display("FAIL illegal_kind: got %0d want %0d", k, e); else pass_cnt++;
        total_cnt++;
        if (l !== 2) $display("FAIL illegal_latency: got %0d want 2", l); else pass_cnt++;
        release_req();
        @(negedge Fc_CLK);
        total_cnt++;
        if (Fc_Req_Err !== 1'b0) $display("FAIL illegal_single_pulse: got %b want 0", Fc_Req_Err); else pass_cnt++;
        total_cnt++;
        if (Fc_Grant !== 1'b0) $display("FAIL illegal_no_grant: got %b want 0", Fc_Grant); else pass_cnt++;
        @(posedge Fc_CLK);
        #1;
        step(3);
        total_cnt++;
        if (Fc_Tx_FC !== 6'b001011) $display("FAIL illegal_tx_fc: got %b want 001011", Fc_Tx_FC); else pass_cnt++;
    endtask

    task automatic test_refresh();
        logic seen;
        Fc_fc_nph = 8'd20;
        step(30);
        total_cnt++;
        if (Fc_Tx_FC[2] !== 1'b0) $display("FAIL refresh_early: got %b want 0", Fc_Tx_FC[2]); else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (Fc_Tx_FC[2] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (seen !== 1'b1) $display("FAIL refresh_nph_flag: got %b want 1", seen); else pass_cnt++;
        step(3);
        total_cnt++;
        if (Fc_Tx_FC !== 6'b101111) $display("FAIL refresh_tx_fc: got %b want 101111", Fc_Tx_FC); else pass_cnt++;
    endtask

    task automatic test_ready_drop();
        int k, l, e;
        send_req(2'd0, 10'd10, K_NONE);
        @(posedge Fc_CLK);
        #1;
        Fc_Bridge_Ready = 1'b0;
        wait_resp(6, k, l);
        e = exp_q.pop_front();
        total_cnt++;
        if (k !== e) $display("FAIL ready_drop_kind: got %0d want %0d", k, e); else pass_cnt++;
        release_req();
        step(2);
        total_cnt++;
        if (Fc_Tx_FC !== 6'b0) $display("FAIL ready_drop_tx_fc: got %b want 000000", Fc_Tx_FC); else pass_cnt++;
        Fc_Bridge_Ready = 1'b1;
        step(10);
        total_cnt++;
        if (Fc_Tx_FC !== 6'b101111) $display("FAIL ready_return_tx_fc: got %b want 101111", Fc_Tx_FC); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int k, l, e;
        send_req(2'd0, 10'd10, K_GRANT);
        wait_resp(10, k, l);
        e = exp_q.pop_front();
        total_cnt++;
        if (k !== e) $display("FAIL pre_reset_grant: got %0d want %0d", k, e); else pass_cnt++;
        #1;
        Fc_RST = 1'b0;
        #1;
        total_cnt++;
        if (Fc_Grant !== 1'b0) $display("FAIL async_grant: got %b want 0", Fc_Grant); else pass_cnt++;
        total_cnt++;
        if (Fc_Req_Err !== 1'b0) $display("FAIL async_err: got %b want 0", Fc_Req_Err); else pass_cnt++;
        total_cnt++;
        if (Fc_Tx_FC !== 6'b0) $display("FAIL async_tx_fc: got %b want 000000", Fc_Tx_FC); else pass_cnt++;
        total_cnt++;
        if (Fc_fc_sel !== 3'b100) $display("FAIL async_fc_sel: got %b want 100", Fc_fc_sel); else pass_cnt++;
        Fc_Req = 1'b0;
        step(2);
        Fc_RST = 1'b1;
        step(1);
    endtask

    initial begin
        Fc_RST          = 1'b0;
        Fc_Bridge_Ready = 1'b0;
        Fc_Req          = 1'b0;
        Fc_Req_Type     = 2'd0;
        Fc_Req_Data     = 10'd0;
        Fc_fc_ph        = 8'd10;
        Fc_fc_pd        = 12'd100;
        Fc_fc_nph       = 8'd2;
        Fc_fc_npd       = 12'd50;
        Fc_fc_cplh      = 8'd5;
        Fc_fc_cpld      = 12'd30;

        test_reset();
        test_snapshot();
        test_posted();
        test_cpl_retry();
        test_illegal();
        test_refresh();
        test_ready_drop();
        test_async_reset();

        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
